// File: rtl/pipe_rx_sync_if.sv
// Bundle between the async pipeline tail, the sync receiver and its clocked consumer.
// The slave modport is the receiver; the master modport drives pipeline/consumer inputs.
`timescale 1ns/1ps
interface pipe_rx_sync_if #(
  parameter int DW    = 3,
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          req_in;
  logic [DW-1:0] data_in;
  logic          ack_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  modport slave (
    input  req_in, data_in, out_ready,
    output ack_out, out_valid, out_data, count
  );

  modport master (
    output req_in, data_in, out_ready,
    input  ack_out, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_rx_sync.sv
// Closes the four-phase pipeline handshake in the clk domain; ack after SYNC_STAGES+1 edges.
// Tokens land in a show-ahead FIFO; when full the ack is withheld so the pipeline stalls.
`timescale 1ns/1ps
module pipe_rx_sync #(
  parameter int DW          = 3,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  pipe_rx_sync_if.slave   if_rx
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ack;
  logic [DW-1:0]          r_mem [DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic                   w_req_s;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], if_rx.req_in};
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];
  // Full is judged on the pre-edge count, so a same-edge pop defers the push by one edge.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = (r_count != '0) && if_rx.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_s && !w_full) begin
          w_push      = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!w_req_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == ST_ACK);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= if_rx.data_in;
    end
  end

  assign if_rx.ack_out   = r_ack;
  assign if_rx.out_valid = (r_count != '0);
  assign if_rx.out_data  = r_mem[r_rptr];
  assign if_rx.count     = r_count;
endmodule

// File: doc/pipe_rx_sync.md
# pipe_rx_sync

Synchronous receiving end for the 3-bit four-phase bundled-data asynchronous pipeline. It accepts tokens from the last pipeline stage (`req`/`data` in, `ack` out), synchronizes the request into the `clk` domain and buffers captured tokens in a small FIFO. It presents them to clocked logic on a valid/ready interface. The block closes the pipeline handshake and is the only clocked consumer of pipeline output.

## Interface

- `DW`, 3: token data width; matches pipeline data width.
- `DEPTH`, 4: FIFO depth in tokens; power of two, ≥2.
- `SYNC_STAGES`, 2: flops in the `req_in` synchronizer; ≥2.

Ports:

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_in`  in  1  four-phase request from the last pipeline stage's `req_out`; asynchronous to `clk`.
- `data_in`  in  DW  bundled data from the last stage's `data_out`; stable while `req_in`=1 and until `ack_out` rises.
- `ack_out`  out  1  acknowledge to the last stage's `ack_in`; registered.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head token this cycle.
- `out_data`  out  DW  head token (show-ahead); valid only when `out_valid`=1.
- `count`  out  $clog2(DEPTH+1)  tokens currently buffered.

## Operation

- Synchronizer: `req_in` passes through a SYNC_STAGES-flop chain. Its output is `req_s`. Only `req_s` feeds the FSM. `data_in` is not synchronized; bundled-data timing guarantees stability.
- FSM, two states:
  - **IDLE** (`ack_out`=0):
    - `req_s`=1 and `count`<DEPTH: push `data_in`, set `ack_out`=1, go to ACK.
    - `req_s`=1 and full: stay in IDLE and withhold ack. This back-pressures the pipeline; no token is lost or overwritten.
  - **ACK** (`ack_out`=1): when `req_s`=0, set `ack_out`=0 and go to IDLE. Otherwise hold.
- Exactly one push per four-phase cycle. A token is never captured twice while in ACK.
- FIFO:
  - Circular buffer with write and read pointers of width $clog2(DEPTH), wrapping DEPTH-1 → 0.
  - `count` tracks occupancy.
  - Pop happens when `out_valid` & `out_ready`.
- Push and pop on the same edge: both occur and `count` is unchanged.
- Full gating uses the pre-edge `count`. A pop on the same edge does not enable a push in that cycle; the push happens one edge later.
- Pop when empty: ignored (`out_valid`=0).
- Reset (`rst`=0), immediate and asynchronous:
  - `ack_out`=0, `out_valid`=0, `count`=0.
  - Pointers 0, state IDLE, synchronizer flops 0.
  - `out_data` is don't-care.
- Reset mid-handshake: `ack_out` drops immediately. If `req_in` is still high after release, it is treated as a new token. The pipeline must share the same reset.

## Timing

- Let E0 be the first edge after `req_in` rises (SYNC_STAGES=2):
  - `req_s`=1 after E1.
  - Push, `ack_out`=1 and `out_valid`=1 all take effect at E2.
- Request-to-ack latency is SYNC_STAGES+1 edges (3 at default). Ack-release latency after `req_in` falls is the same.
- Minimum full four-phase cycle: 6 clocks plus pipeline delays. Sustained throughput: 1 token per 6 clocks at default.
- Push-to-output latency: 0 extra cycles. `out_data` shows the head on the same edge the push into an empty FIFO occurs.
- Full stall release:
  - Pop at edge P frees a slot.
  - The pending token is pushed at P+1 and `ack_out` rises at P+1.
- `ack_out` is glitch-free because it is driven directly from a flop.

## Test plan

- **Reset:** hold `rst`=0 with `req_in`=1 → `ack_out`=0, `out_valid`=0, `count`=0. Release → first token captured after 3 edges.
- **Single token:** `data_in`=3'b101, `req_in` rises, `out_ready`=0 → `ack_out`=1 at E2, `out_valid`=1, `out_data`=5, `count`=1. Drop `req_in` → `ack_out`=0 three edges later.
- **Full back-pressure:**
  - Send tokens 1,2,3,4 with `out_ready`=0 → `count`=4.
  - Fifth token 6 with `req_in` held high → `ack_out` stays 0 for 20 cycles.
  - Pulse `out_ready` for one cycle → pops 1, token 6 pushed next edge, `count`=4.
- **Ordering and wrap:** tokens 0..7 through the 3-stage pipeline with random `out_ready` → output 0,1,…,7 exactly once each, in order; pointers wrap with no loss or duplication.
- **Simultaneous push/pop:** with `count`=2 and `out_ready`=1 on the push edge → `count` stays 2, head advances.
- **Mid-handshake reset:** assert `rst`=0 while in ACK with `count`=3 → `ack_out`=0 and `count`=0 immediately, without waiting for a clock edge.
